// File: rtl/button_step_conditioner.sv
// button_step_conditioner
// Turns a raw, bouncing push-button into single-cycle step pulses for the
// dynamic LED lights block. There is one step per press. While the button
// is held and rep_en is set, extra steps auto-repeat after an initial delay.
module button_step_conditioner #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int REPEAT_DELAY    = 8,
   parameter int REPEAT_PERIOD   = 4,
   parameter int CNT_W           = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_raw,
   input  logic       rep_en,
   output logic       button,
   output logic       held,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_DELAY  = 2'b01,
      S_REPEAT = 2'b10
   } state_t;

   localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] DELAY_CNT = CNT_W'(REPEAT_DELAY);
   localparam logic [CNT_W-1:0] PER_CNT   = CNT_W'(REPEAT_PERIOD);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
   logic             held_q, held_d;
   logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
   logic             button_q, button_d;
   state_t           state_q, state_d;

   logic             held_rise;
   logic             held_fall;

   // Two-flop synchroniser on the asynchronous button input.
   always_comb begin
      sync1_d = btn_raw;
      sync2_d = sync1_q;
   end

   // Debounce: a new level is accepted only after DEBOUNCE_CYCLES
   // consecutive differing samples; any agreeing sample restarts the count.
   always_comb begin
      held_d   = held_q;
      db_cnt_d = db_cnt_q;
      if (sync2_q != held_q) begin
         if (db_cnt_q >= DB_LAST) begin
            held_d   = sync2_q;
            db_cnt_d = '0;
         end else if (db_cnt_q != CNT_MAX) begin
            db_cnt_d = db_cnt_q + CNT_ONE;
         end
      end else begin
         db_cnt_d = '0;
      end
   end

   // The FSM reacts on the same edge that updates held, so the edges are
   // taken from the next-state value rather than from the held register.
   always_comb begin
      held_rise = held_d & ~held_q;
      held_fall = ~held_d & held_q;
   end

   // Step FSM: first step on press, then delay, then periodic repeat.
   // Release takes priority over any pulse that falls due on the same edge.
   always_comb begin
      state_d   = state_q;
      rep_cnt_d = rep_cnt_q;
      button_d  = 1'b0;
      if (held_fall) begin
         state_d   = S_IDLE;
         rep_cnt_d = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (held_rise) begin
                  button_d  = 1'b1;
                  rep_cnt_d = CNT_ONE;
                  // With repeat disabled the hold still parks in REPEAT;
                  // rep_en gating below keeps it silent.
                  state_d   = rep_en ? S_DELAY : S_REPEAT;
               end
            end
            S_DELAY: begin
               if (rep_en) begin
                  if (rep_cnt_q >= DELAY_CNT) begin
                     button_d  = 1'b1;
                     rep_cnt_d = CNT_ONE;
                     state_d   = S_REPEAT;
                  end else if (rep_cnt_q != CNT_MAX) begin
                     rep_cnt_d = rep_cnt_q + CNT_ONE;
                  end
               end
            end
            S_REPEAT: begin
               if (rep_en) begin
                  if (rep_cnt_q >= PER_CNT) begin
                     button_d  = 1'b1;
                     rep_cnt_d = CNT_ONE;
                  end else if (rep_cnt_q != CNT_MAX) begin
                     rep_cnt_d = rep_cnt_q + CNT_ONE;
                  end
               end
            end
            default: begin
               state_d   = S_IDLE;
               rep_cnt_d = '0;
            end
         endcase
      end
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         db_cnt_q  <= '0;
         held_q    <= 1'b0;
         rep_cnt_q <= '0;
         button_q  <= 1'b0;
         state_q   <= S_IDLE;
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         db_cnt_q  <= db_cnt_d;
         held_q    <= held_d;
         rep_cnt_q <= rep_cnt_d;
         button_q  <= button_d;
         state_q   <= state_d;
      end
   end

   assign button = button_q;
   assign held   = held_q;
   assign state  = state_q;

endmodule

// File: tb/tb_button_step_conditioner.sv
// Testbench for button_step_conditioner: each scenario is a per-edge
// stimulus table. Expected outputs are derived from the press/release edges
// and the rep_en table. They are queued when an edge is driven and then
// compared after that edge.
module tb_button_step_conditioner;

   localparam int DB  = 4;
   localparam int DLY = 8;
   localparam int PER = 4;
   localparam int NO_EDGE = 1000;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       btn_raw = 1'b0;
   logic       rep_en = 1'b0;
   logic       button;
   logic       held;
   logic [1:0] state;

   typedef struct {
      logic       btn;
      logic       hld;
      logic [1:0] st;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   bit   btn_seq [1:128];
   bit   rep_seq [1:128];
   int   press_e;
   int   rel_e;

   button_step_conditioner #(
      .DEBOUNCE_CYCLES(DB),
      .REPEAT_DELAY   (DLY),
      .REPEAT_PERIOD  (PER),
      .CNT_W          (8)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .btn_raw(btn_raw),
      .rep_en (rep_en),
      .button (button),
      .held   (held),
      .state  (state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", tag, obs, exp_v);
      end
   endtask

   // Expected outputs at edge e. held is high from press_e up to rel_e.
   // The first step lands on press_e. The repeat counter only advances on
   // edges where rep_en is 1, so those edges count as progress k.
   function automatic exp_t model(input int e);
      exp_t x;
      int   off;
      int   k;
      x.btn = 1'b0;
      x.hld = 1'b0;
      x.st  = 2'b00;
      if (press_e == 0 || e < press_e || e >= rel_e) return x;
      x.hld = 1'b1;
      if (e == press_e) begin
         x.btn = 1'b1;
         x.st  = rep_seq[press_e] ? 2'b01 : 2'b10;
         return x;
      end
      off = 0;
      for (int i = press_e + 1; i <= e; i++) if (!rep_seq[i]) off++;
      k = e - press_e - off;
      if (rep_seq[press_e]) begin
         if (k < DLY) begin
            x.st = 2'b01;
         end else begin
            x.st  = 2'b10;
            x.btn = rep_seq[e] && ((k - DLY) % PER == 0);
         end
      end else begin
         x.st  = 2'b10;
         x.btn = rep_seq[e] && (k > 0) && (k % PER == 0);
      end
      return x;
   endfunction

   task automatic fill(input int hi_from, input int hi_to, input bit r);
      for (int i = 1; i <= 128; i++) begin
         btn_seq[i] = (i >= hi_from && i <= hi_to);
         rep_seq[i] = r;
      end
   endtask

   task automatic apply_reset();
      rst     = 1'b0;
      btn_raw = 1'b0;
      rep_en  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset button", {7'd0, button}, 8'd0);
      chk("reset held",   {7'd0, held},   8'd0);
      chk("reset state",  {6'd0, state},  8'd0);
      rst = 1'b1;
   endtask

   // Drive one edge, queue its expectation, then check it after the edge.
   task automatic do_edge(input string name, input int e, input logic r_n);
      exp_t x;
      btn_raw = btn_seq[e];
      rep_en  = rep_seq[e];
      rst     = r_n;
      if (r_n) begin
         sb_q.push_back(model(e));
      end else begin
         x.btn = 1'b0;
         x.hld = 1'b0;
         x.st  = 2'b00;
         sb_q.push_back(x);
      end
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s e%0d: scoreboard empty", name, e);
      end else begin
         x = sb_q.pop_front();
         chk($sformatf("%s e%0d button", name, e), {7'd0, button}, {7'd0, x.btn});
         chk($sformatf("%s e%0d held", name, e),   {7'd0, held},   {7'd0, x.hld});
         chk($sformatf("%s e%0d state", name, e),  {6'd0, state},  {6'd0, x.st});
      end
   endtask

   task automatic run(input string name, input int n);
      int bad0;
      bad0 = n_bad;
      for (int e = 1; e <= n; e++) do_edge(name, e, 1'b1);
      $display("scenario %s: %0d edges, %0d new mismatches", name, n, n_bad - bad0);
   endtask

   initial begin
      apply_reset();

      // Clean press, held for edges 1..32 with repeat enabled.
      fill(1, 32, 1'b1);
      press_e = 6; rel_e = 38;
      run("clean", 45);

      // A 3-sample glitch must not be accepted.
      apply_reset();
      fill(1, 3, 1'b1);
      press_e = 0; rel_e = NO_EDGE;
      run("glitch", 15);

      // Bounce 1,0,1,1,0,1 then steady 1; the high run starts at edge 6.
      apply_reset();
      fill(6, 15, 1'b1);
      btn_seq[1] = 1'b1; btn_seq[3] = 1'b1; btn_seq[4] = 1'b1;
      press_e = 11; rel_e = 21;
      run("bounce", 30);

      // Repeat disabled: a single step, then hold in REPEAT without pulses.
      apply_reset();
      fill(1, 40, 1'b0);
      press_e = 6; rel_e = 46;
      run("norep", 55);

      // Reset mid-repeat at edge 20 while the button stays pressed.
      apply_reset();
      fill(1, 20, 1'b1);
      press_e = 6; rel_e = NO_EDGE;
      run("prerst", 19);
      do_edge("midrst", 20, 1'b0);
      rst = 1'b1;
      fill(1, 20, 1'b1);
      press_e = 6; rel_e = 26;
      run("postrst", 32);

      // Short press: one step and no repeat.
      apply_reset();
      fill(1, 6, 1'b1);
      press_e = 6; rel_e = 12;
      run("short", 20);

      // rep_en drops during DELAY; the counter freezes and later resumes.
      apply_reset();
      fill(1, 30, 1'b1);
      for (int i = 10; i <= 13; i++) rep_seq[i] = 1'b0;
      press_e = 6; rel_e = 36;
      run("repgap", 40);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
